// File: rtl/cv32e40s_glitch_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cv32e40s_glitch_controller_if : control/config/status bundle for the glitch controller
// Revision: 1.0
// ----------------------------------------------------------------------------
interface cv32e40s_glitch_controller_if #(
  parameter int CNT_WIDTH = 16,
  parameter int REP_WIDTH = 8
);
  logic                 arm_i;
  logic                 abort_i;
  logic                 trigger_i;
  logic                 cfg_specific_i;
  logic [CNT_WIDTH-1:0] cfg_delay_i;
  logic [CNT_WIDTH-1:0] cfg_width_i;
  logic [CNT_WIDTH-1:0] cfg_gap_i;
  logic [REP_WIDTH-1:0] cfg_repeat_i;
  logic                 glitch_en_o;
  logic                 glitch_spec_en_o;
  logic                 busy_o;
  logic                 done_o;
  logic [REP_WIDTH-1:0] pulse_cnt_o;

  modport master (
    output arm_i, abort_i, trigger_i, cfg_specific_i,
    output cfg_delay_i, cfg_width_i, cfg_gap_i, cfg_repeat_i,
    input  glitch_en_o, glitch_spec_en_o, busy_o, done_o, pulse_cnt_o
  );

  modport slave (
    input  arm_i, abort_i, trigger_i, cfg_specific_i,
    input  cfg_delay_i, cfg_width_i, cfg_gap_i, cfg_repeat_i,
    output glitch_en_o, glitch_spec_en_o, busy_o, done_o, pulse_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40s_glitch_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cv32e40s_glitch_controller : sequences delay / pulse / gap bursts for a glitch injector
// Revision: 1.0
// ----------------------------------------------------------------------------
module cv32e40s_glitch_controller #(
  parameter int CNT_WIDTH = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cv32e40s_glitch_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] delay_q, delay_d;
  logic [CNT_WIDTH-1:0] width_q, width_d;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic [REP_WIDTH-1:0] repeat_q, repeat_d;
  logic                 specific_q, specific_d;
  logic [REP_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic                 glitch_en_q, glitch_en_d;
  logic                 glitch_spec_en_q, glitch_spec_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 enter_pulse;
  logic [CNT_WIDTH-1:0] width_eff;
  logic [CNT_WIDTH-1:0] gap_eff;
  logic [REP_WIDTH-1:0] repeat_eff;

  // Zero-valued width/gap/repeat behave as one so pulses never vanish or merge.
  assign width_eff  = (width_q  == '0) ? CNT_ONE : width_q;
  assign gap_eff    = (gap_q    == '0) ? CNT_ONE : gap_q;
  assign repeat_eff = (repeat_q == '0) ? REP_ONE : repeat_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    delay_d     = delay_q;
    width_d     = width_q;
    gap_d       = gap_q;
    repeat_d    = repeat_q;
    specific_d  = specific_q;
    pulse_cnt_d = pulse_cnt_q;
    enter_pulse = 1'b0;

    if (bus.abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.arm_i) begin
            delay_d     = bus.cfg_delay_i;
            width_d     = bus.cfg_width_i;
            gap_d       = bus.cfg_gap_i;
            repeat_d    = bus.cfg_repeat_i;
            specific_d  = bus.cfg_specific_i;
            pulse_cnt_d = '0;
            state_d     = ARMED;
          end
        end
        ARMED: begin
          if (bus.trigger_i) begin
            if (delay_q != '0) begin
              state_d = DELAY;
              cnt_d   = delay_q;
            end else begin
              enter_pulse = 1'b1;
            end
          end
        end
        DELAY: begin
          if (cnt_q == CNT_ONE) enter_pulse = 1'b1;
          else                  cnt_d = cnt_q - CNT_ONE;
        end
        PULSE: begin
          if (cnt_q == CNT_ONE) begin
            if (pulse_cnt_q == repeat_eff) begin
              state_d = DONE;
            end else begin
              state_d = GAP;
              cnt_d   = gap_eff;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_q == CNT_ONE) enter_pulse = 1'b1;
          else                  cnt_d = cnt_q - CNT_ONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (enter_pulse) begin
        state_d = PULSE;
        cnt_d   = width_eff;
        if (pulse_cnt_q != '1) pulse_cnt_d = pulse_cnt_q + REP_ONE;
      end
    end

    // Injector outputs trail the state by one cycle; abort kills them at once.
    glitch_en_d      = !bus.abort_i && (state_q == PULSE) && !specific_q;
    glitch_spec_en_d = !bus.abort_i && (state_q == PULSE) &&  specific_q;
    done_d           = !bus.abort_i && (state_q == DONE);
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      delay_q          <= '0;
      width_q          <= '0;
      gap_q            <= '0;
      repeat_q         <= '0;
      specific_q       <= 1'b0;
      pulse_cnt_q      <= '0;
      glitch_en_q      <= 1'b0;
      glitch_spec_en_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      delay_q          <= delay_d;
      width_q          <= width_d;
      gap_q            <= gap_d;
      repeat_q         <= repeat_d;
      specific_q       <= specific_d;
      pulse_cnt_q      <= pulse_cnt_d;
      glitch_en_q      <= glitch_en_d;
      glitch_spec_en_q <= glitch_spec_en_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign bus.glitch_en_o      = glitch_en_q;
  assign bus.glitch_spec_en_o = glitch_spec_en_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.pulse_cnt_o      = pulse_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40s_glitch_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cv32e40s_glitch_controller : table-driven campaigns with a per-cycle scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cv32e40s_glitch_controller;

  localparam int CW = 16;
  localparam int RW = 8;

  typedef struct {
    logic spec;
    int   delay;
    int   width;
    int   gap;
    int   rep;
    int   exp_pulses;
  } vec_t;

  typedef struct {
    logic en;
    logic spec;
    logic done;
    logic busy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vecs[5];
  int   kd;

  always #5 clk = ~clk;

  cv32e40s_glitch_controller_if #(.CNT_WIDTH(CW), .REP_WIDTH(RW)) bus ();

  cv32e40s_glitch_controller #(.CNT_WIDTH(CW), .REP_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_glitch_en",      int'(bus.glitch_en_o),      int'(e.en));
      check("sb_glitch_spec_en", int'(bus.glitch_spec_en_o), int'(e.spec));
      check("sb_done",           int'(bus.done_o),           int'(e.done));
      check("sb_busy",           int'(bus.busy_o),           int'(e.busy));
      check("sb_mutex",          int'(bus.glitch_en_o & bus.glitch_spec_en_o), 0);
    end
  endtask

  // Expected samples for the edge that samples the trigger (k=0) onwards.
  task automatic push_campaign(input int d, input int w, input int g, input int r,
                               input logic s, output int k_done);
    int   we, ge, re, off;
    logic hi;
    exp_t e;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    re = (r == 0) ? 1 : r;
    k_done = 1 + d + re * we + (re - 1) * ge;
    for (int k = 0; k <= k_done + 1; k++) begin
      hi = 1'b0;
      if (k >= 1 + d) begin
        off = k - 1 - d;
        if ((off / (we + ge)) < re && (off % (we + ge)) < we) hi = 1'b1;
      end
      e.en   = hi && !s;
      e.spec = hi && s;
      e.done = (k == k_done);
      e.busy = (k < k_done);
      exp_q.push_back(e);
    end
  endtask

  task automatic arm(input int d, input int w, input int g, input int r, input logic s);
    bus.cfg_delay_i    = CW'(d);
    bus.cfg_width_i    = CW'(w);
    bus.cfg_gap_i      = CW'(g);
    bus.cfg_repeat_i   = RW'(r);
    bus.cfg_specific_i = s;
    bus.arm_i          = 1'b1;
    step();
    bus.arm_i          = 1'b0;
    // Config must be ignored once latched.
    bus.cfg_delay_i    = CW'($urandom);
    bus.cfg_width_i    = CW'($urandom);
    bus.cfg_gap_i      = CW'($urandom);
    bus.cfg_repeat_i   = RW'($urandom);
    bus.cfg_specific_i = ~s;
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int k_done;
    arm(v.delay, v.width, v.gap, v.rep, v.spec);
    check($sformatf("v%0d_armed_busy", idx), int'(bus.busy_o), 1);
    step();
    check($sformatf("v%0d_armed_quiet", idx),
          int'(bus.glitch_en_o | bus.glitch_spec_en_o), 0);
    push_campaign(v.delay, v.width, v.gap, v.rep, v.spec, k_done);
    bus.trigger_i = 1'b1;
    step();
    bus.trigger_i = 1'b0;
    repeat (k_done + 1) step();
    check($sformatf("v%0d_sb_drained", idx), exp_q.size(), 0);
    check($sformatf("v%0d_pulse_cnt", idx), int'(bus.pulse_cnt_o), v.exp_pulses);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{spec: 1'b0, delay: 3, width: 2, gap: 1, rep: 2, exp_pulses: 2};
    vecs[1] = '{spec: 1'b1, delay: 0, width: 0, gap: 0, rep: 0, exp_pulses: 1};
    vecs[2] = '{spec: 1'b0, delay: 0, width: 1, gap: 0, rep: 3, exp_pulses: 3};
    vecs[3] = '{spec: 1'b1, delay: 5, width: 3, gap: 2, rep: 1, exp_pulses: 1};
    vecs[4] = '{spec: 1'b1, delay: 1, width: 1, gap: 4, rep: 4, exp_pulses: 4};

    bus.arm_i = 1'b0; bus.abort_i = 1'b0; bus.trigger_i = 1'b0;
    bus.cfg_specific_i = 1'b0; bus.cfg_delay_i = '0; bus.cfg_width_i = '0;
    bus.cfg_gap_i = '0; bus.cfg_repeat_i = '0;

    #12;
    check("rst_glitch_en",   int'(bus.glitch_en_o),      0);
    check("rst_glitch_spec", int'(bus.glitch_spec_en_o), 0);
    check("rst_busy",        int'(bus.busy_o),           0);
    check("rst_done",        int'(bus.done_o),           0);
    check("rst_pulse_cnt",   int'(bus.pulse_cnt_o),      0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vector(vecs[i], i);

    // Re-arm with different config during DELAY must not disturb the campaign.
    arm(3, 2, 1, 2, 1'b0);
    push_campaign(3, 2, 1, 2, 1'b0, kd);
    bus.trigger_i = 1'b1;
    step();
    bus.trigger_i      = 1'b0;
    bus.cfg_delay_i    = CW'(0);
    bus.cfg_width_i    = CW'(5);
    bus.cfg_repeat_i   = RW'(1);
    bus.cfg_specific_i = 1'b1;
    bus.arm_i          = 1'b1;
    step();
    bus.arm_i = 1'b0;
    repeat (kd) step();
    check("rearm_sb_drained", exp_q.size(), 0);
    check("rearm_pulse_cnt",  int'(bus.pulse_cnt_o), 2);
    exp_q.delete();

    // Abort during the second of three pulses.
    arm(0, 3, 1, 3, 1'b0);
    bus.trigger_i = 1'b1;
    step();
    bus.trigger_i = 1'b0;
    repeat (5) step();
    check("abort_pre_high", int'(bus.glitch_en_o), 1);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    check("abort_glitch_en", int'(bus.glitch_en_o),      0);
    check("abort_spec_en",   int'(bus.glitch_spec_en_o), 0);
    check("abort_busy",      int'(bus.busy_o),           0);
    check("abort_done",      int'(bus.done_o),           0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_no_done",  int'(bus.done_o),      0);
      check("abort_no_pulse", int'(bus.glitch_en_o), 0);
    end
    check("abort_pulse_cnt", int'(bus.pulse_cnt_o), 2);

    // Asynchronous reset in the middle of a pulse.
    arm(0, 10, 1, 1, 1'b1);
    bus.trigger_i = 1'b1;
    step();
    bus.trigger_i = 1'b0;
    repeat (3) step();
    check("arst_pre_high", int'(bus.glitch_spec_en_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_spec_en",   int'(bus.glitch_spec_en_o), 0);
    check("arst_glitch_en", int'(bus.glitch_en_o),      0);
    check("arst_busy",      int'(bus.busy_o),           0);
    check("arst_pulse_cnt", int'(bus.pulse_cnt_o),      0);
    #2;
    rst_n = 1'b1;
    step();
    check("arst_post_busy", int'(bus.busy_o), 0);

    // Arm and abort together in IDLE: abort wins, trigger then ignored.
    bus.cfg_delay_i = CW'(0); bus.cfg_width_i = CW'(1); bus.cfg_repeat_i = RW'(1);
    bus.arm_i   = 1'b1;
    bus.abort_i = 1'b1;
    step();
    bus.arm_i   = 1'b0;
    bus.abort_i = 1'b0;
    check("armabort_busy", int'(bus.busy_o), 0);
    bus.trigger_i = 1'b1;
    step();
    bus.trigger_i = 1'b0;
    step();
    check("armabort_trig_busy", int'(bus.busy_o), 0);
    check("armabort_trig_quiet", int'(bus.glitch_en_o | bus.glitch_spec_en_o), 0);

    // Normal operation resumes after the reset and abort sequences.
    run_vector(vecs[0], 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40s_glitch_controller.md
CV32E40S_GLITCH_CONTROLLER -- requirements
Module: cv32e40s_glitch_controller

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of the delay, pulse-width and gap counters.
REQ-002 Parameter REP_WIDTH, default 8, width of the pulse-repeat counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 arm_i  input  1  one-cycle request to latch config and arm.
REQ-006 abort_i  input  1  cancel any activity.
REQ-007 trigger_i  input  1  start-of-campaign event, level-sampled while armed.
REQ-008 cfg_specific_i  input  1  1 = drive enable_specific path, 0 = drive random-scramble path.
REQ-009 cfg_delay_i  input  CNT_WIDTH  cycles from trigger to first pulse.
REQ-010 cfg_width_i  input  CNT_WIDTH  pulse length in cycles.
REQ-011 cfg_gap_i  input  CNT_WIDTH  idle cycles between pulses.
REQ-012 cfg_repeat_i  input  REP_WIDTH  number of pulses.
REQ-013 glitch_en_o  output  1  to injector enable (random mode).
REQ-014 glitch_spec_en_o  output  1  to injector enable_specific.
REQ-015 busy_o  output  1  high in any state other than IDLE.
REQ-016 done_o  output  1  one-cycle pulse on campaign completion.
REQ-017 pulse_cnt_o  output  REP_WIDTH  pulses issued in current/last campaign.

Function
REQ-018 FSM states SHALL be IDLE, ARMED, DELAY, PULSE, GAP, DONE; all outputs registered.
REQ-019 IDLE + arm_i: latch all cfg_* into shadow registers, clear pulse_cnt_o, go ARMED; cfg_* ignored at all other times.
REQ-020 ARMED + trigger_i=1 at edge T: go DELAY if latched delay>0, else PULSE; first pulse output high from edge T+1+delay.
REQ-021 DELAY: count latched delay cycles, then PULSE.
REQ-022 PULSE: exactly one of glitch_en_o/glitch_spec_en_o high (selected by latched cfg_specific) for width cycles; width=0 treated as 1.
REQ-023 Each PULSE entry increments pulse_cnt_o by 1 (saturating at all-ones).
REQ-024 End of PULSE: if pulse_cnt_o == repeat go DONE, else GAP; repeat=0 treated as 1.
REQ-025 GAP: both glitch outputs low for gap cycles, then PULSE; gap=0 treated as 1 (pulses never merge).
REQ-026 DONE: done_o high for exactly that one cycle, then IDLE.
REQ-027 glitch_en_o and glitch_spec_en_o SHALL never be high simultaneously.
REQ-028 abort_i in any state: next edge forces IDLE, both glitch outputs low, done_o low; pulse_cnt_o retained; abort beats arm_i and trigger_i in the same cycle.
REQ-029 arm_i outside IDLE SHALL be ignored (no re-latch); trigger_i outside ARMED ignored.
REQ-030 Counters SHALL not wrap: max-value delay/width/gap (2^CNT_WIDTH-1) yields exactly that many cycles.

Reset
REQ-031 rst_n low: immediately (asynchronously) state IDLE, all outputs 0, shadow config and counters 0.
REQ-032 Reset mid-PULSE SHALL drop the glitch output without waiting for a clock edge.

Verification
REQ-033 arm (delay=3,width=2,gap=1,repeat=2,specific=0), trigger at T -> glitch_en_o high T+4..T+5, low T+6, high T+7..T+8, done_o at T+9, pulse_cnt_o=2.
REQ-034 specific=1, delay=0, width=0, repeat=0, trigger at T -> glitch_spec_en_o high only T+1, glitch_en_o never high, done_o at T+2.
REQ-035 abort_i during second pulse of repeat=3 campaign -> outputs low next edge, IDLE, no done_o, pulse_cnt_o=2.
REQ-036 cfg_* changed and arm_i re-pulsed while DELAY -> timing matches originally latched config.
REQ-037 rst_n asserted asynchronously mid-PULSE -> glitch output 0 before next clk edge, busy_o=0.
REQ-038 arm_i and abort_i same cycle in IDLE -> stays IDLE, busy_o=0.
